serial_add_sequencer: RTL and testbench

Multi-cycle controller that performs WIDTH-bit add or subtract by time-sharing one 4-bit ripple carry adder, one nibble per clock, LSB nibble first. Between nibbles the carry is held in a register. The block accepts an operation through a start/busy/done handshake and returns the sum plus carry-out and signed-overflow flags. It is the sequencing layer above the 4-bit adder, which lets wide arithmetic reuse the small adder instead of instantiating WIDTH/4 copies.

---
 rtl/serial_add_sequencer_pkg.sv | 13 +
 rtl/serial_add_sequencer_rca.sv | 26 ++
 rtl/serial_add_sequencer.sv | 104 ++++++++++
 tb/tb_serial_add_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
`timescale 1ns/1ps
package serial_add_sequencer_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sequencer_rca.sv
// Nibble-wide ripple carry adder shared across all nibbles of the operation.
`timescale 1ns/1ps
module ripple_carry_adder
  import serial_add_sequencer_pkg::*;
(
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout,
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single
// 4-bit adder, with start/busy/done handshake and carry/overflow flags.
`timescale 1ns/1ps
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                cout_nib;

  // Nibble select written as a compare-per-slice mux so the index stays in range
  // for every WIDTH, including non-power-of-two nibble counts.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_nib = a_reg[k*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder u_rca (
    .S    (sum_nib),
    .Cout (cout_nib),
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_reg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= sub ? ~B : B;
            carry_reg <= sub;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (cnt == CNT_W'(k)) S[k*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          end
          carry_reg <= cout_nib;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            Cout  <= cout_nib;
            ovf   <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1]) & (sum_nib[NIBBLE_W-1] ^ a_reg[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench: driver queues hand-computed results, monitor checks on done.
`timescale 1ns/1ps
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset, start, sub;
  logic [WIDTH-1:0] A, B, S;
  logic             Cout, ovf, busy, done;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int unsigned      acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc      = 0;
  int unsigned pass_cnt = 0;
  int unsigned total    = 0;
  int unsigned busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (busy && done) check("busy_done_exclusive", 32'd1, 32'd0);
    if (busy) busy_run++;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("S", 32'(S), 32'(mon_e.s));
        check("Cout", 32'(Cout), 32'(mon_e.c));
        check("ovf", 32'(ovf), 32'(mon_e.o));
        check("done_latency", cyc + 1 - mon_e.acc, 32'd5);
        check("busy_cycles", busy_run, 32'd4);
      end
      busy_run = 0;
    end else if (!busy) begin
      busy_run = 0;
    end
  end

  task automatic push(input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s   = s;
    e.c   = c;
    e.o   = o;
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    A   = a;
    B   = b;
    sub = s;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    drive(a, b, s);
    start = 1'b1;
    push(es, ec, eo);
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_S", 32'(S), 32'd0);
    check("reset_Cout", 32'(Cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_S", 32'(S), 32'h5555);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_done", 32'(done), 32'd0);

    run_op("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0);
    start = 1'b1;
    push(16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(16'hABCD, 16'h0F0F, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start");

    // Reset during the second RUN cycle aborts with no done.
    @(negedge clk);
    drive(16'hAAAA, 16'h1111, 1'b0);
    start = 1'b1;
    push(16'hBBBB, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_S", 32'(S), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Back-to-back: start held through DONE accepts the second operation.
    @(negedge clk);
    drive(16'h1234, 16'h1111, 1'b0);
    start = 1'b1;
    push(16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'h8000, 16'h0001, 1'b1);
    wait_done("b2b_first");
    push(16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
